// File: rtl/hnoc_pkg.sv
// Shared switch definitions: default flit width, the address field inside a flit
// and the port-arbiter FSM encoding.
package hnoc_pkg;

  localparam int DefDataWidth = 32;
  localparam int AddrMsb      = 31;
  localparam int AddrLsb      = 24;

  localparam logic StIdleEnc   = 1'b0;
  localparam logic StLockedEnc = 1'b1;

  typedef enum logic {
    ST_IDLE   = StIdleEnc,
    ST_LOCKED = StLockedEnc
  } state_t;

  function automatic logic [AddrMsb-AddrLsb:0] flit_addr(input logic [DefDataWidth-1:0] flit);
    return flit[AddrMsb:AddrLsb];
  endfunction

endpackage

// File: rtl/switch_port_arbiter_if.sv
// Requester-side flit bus plus the single registered output flit of one switch port.
// slave is the arbiter's view, master the surrounding switch's view.
interface switch_port_arbiter_if
  import hnoc_pkg::*;
#(
  parameter int DataWidth = DefDataWidth,
  parameter int NumReq    = 3
);

  logic [NumReq*DataWidth-1:0] i_req_data;
  logic [NumReq-1:0]           i_req_valid;
  logic [NumReq-1:0]           o_req_ready;
  logic [DataWidth-1:0]        o_data;
  logic                        o_data_valid;
  logic                        i_data_ready;
  logic [NumReq-1:0]           o_grant;
  logic                        o_busy;

  modport slave (
    input  i_req_data, i_req_valid, i_data_ready,
    output o_req_ready, o_data, o_data_valid, o_grant, o_busy
  );

  modport master (
    output i_req_data, i_req_valid, i_data_ready,
    input  o_req_ready, o_data, o_data_valid, o_grant, o_busy
  );

endinterface

// File: rtl/rr_pick.sv
// Rotating-priority pick: first set request bit searching upward from last+1 with wrap.
// Purely combinational; returns a one-hot winner and whether any request was seen.
module rr_pick #(
  parameter int NumReq = 3,
  parameter int IdxW   = 2
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   last,
  output logic [NumReq-1:0] winner,
  output logic              any
);

  logic [IdxW-1:0] idx;
  logic            found;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= NumReq; i++) begin
      idx = IdxW'((int'(last) + i) % NumReq);
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/switch_port_arbiter.sv
// Packet-locked round-robin arbiter for one output port; grant 1 cycle after request, flit 1 cycle after accept.
// Owner's ready follows the output register (~valid | downstream ready); everyone else sees ready low.
module switch_port_arbiter
  import hnoc_pkg::*;
#(
  parameter int DataWidth = DefDataWidth,
  parameter int NumReq    = 3,
  parameter int PktLen    = 1
) (
  input logic                  i_mclk,
  input logic                  i_reset_n,
  switch_port_arbiter_if.slave bus
);

  localparam int IdxW = $clog2(NumReq);

  state_t                state, state_nx;
  logic [NumReq-1:0]     grant, grant_nx;
  logic [7:0]            beat, beat_nx;
  logic [IdxW-1:0]       last_winner, last_nx;
  logic [IdxW-1:0]       grant_idx;
  logic [NumReq-1:0]     pick;
  logic                  any_vld;
  logic [NumReq-1:0]     ready;
  logic                  xfer;
  logic [DataWidth-1:0]  flit_sel;
  logic [DataWidth-1:0]  flit;
  logic                  flit_vld;

  rr_pick #(.NumReq(NumReq), .IdxW(IdxW)) u_pick (
    .req    (bus.i_req_valid),
    .last   (last_winner),
    .winner (pick),
    .any    (any_vld)
  );

  always_comb begin
    grant_idx = '0;
    flit_sel  = '0;
    for (int k = 0; k < NumReq; k++) begin
      if (grant[k]) begin
        grant_idx = IdxW'(k);
        flit_sel  = bus.i_req_data[k*DataWidth +: DataWidth];
      end
    end
  end

  // Only the owner may push, and only when the output register will have room.
  assign ready = (state == ST_LOCKED) ? (grant & {NumReq{~flit_vld | bus.i_data_ready}}) : '0;
  assign xfer  = |(bus.i_req_valid & ready);

  always_comb begin
    state_nx = state;
    grant_nx = grant;
    beat_nx  = beat;
    last_nx  = last_winner;
    case (state)
      ST_IDLE: begin
        if (any_vld) begin
          state_nx = ST_LOCKED;
          grant_nx = pick;
          beat_nx  = '0;
        end
      end
      ST_LOCKED: begin
        if (xfer) begin
          beat_nx = beat + 8'd1;
          if (beat == 8'(PktLen - 1)) begin
            state_nx = ST_IDLE;
            grant_nx = '0;
            last_nx  = grant_idx;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_mclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= ST_IDLE;
      grant       <= '0;
      beat        <= '0;
      last_winner <= IdxW'(NumReq - 1);
    end else begin
      state       <= state_nx;
      grant       <= grant_nx;
      beat        <= beat_nx;
      last_winner <= last_nx;
    end
  end

  // A new flit overwrites the register in the same edge the old one drains.
  always_ff @(posedge i_mclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      flit     <= '0;
      flit_vld <= 1'b0;
    end else if (xfer) begin
      flit     <= flit_sel;
      flit_vld <= 1'b1;
    end else if (flit_vld && bus.i_data_ready) begin
      flit_vld <= 1'b0;
    end
  end

  assign bus.o_req_ready  = ready;
  assign bus.o_grant      = grant;
  assign bus.o_data       = flit;
  assign bus.o_data_valid = flit_vld;
  assign bus.o_busy       = (state == ST_LOCKED);

endmodule

// File: tb/tb_switch_port_arbiter.sv
// Directed and randomised checks of switch_port_arbiter: one instance with 1-flit packets (a)
// and one with 4-flit packets (b), driven by flit sources that hold data until accepted.
module tb_switch_port_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  switch_port_arbiter_if #(.DataWidth(32), .NumReq(3)) ifa ();
  switch_port_arbiter_if #(.DataWidth(32), .NumReq(3)) ifb ();

  switch_port_arbiter #(.DataWidth(32), .NumReq(3), .PktLen(1)) dut_a (
    .i_mclk    (clk),
    .i_reset_n (rst_n),
    .bus       (ifa)
  );

  switch_port_arbiter #(.DataWidth(32), .NumReq(3), .PktLen(4)) dut_b (
    .i_mclk    (clk),
    .i_reset_n (rst_n),
    .bus       (ifb)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int seqa [3];
  int seqb [3];
  logic [31:0] sbq [$];
  logic sb_on = 1'b0;
  int   beat_cnt, owner;
  int   skip [3];
  logic want [3];
  logic drained;

  // expected tables, one entry per cycle of each directed sequence
  logic [2:0]  g34 [9]  = '{0, 1, 0, 2, 0, 4, 0, 1, 0};
  logic        v34 [9]  = '{0, 0, 1, 0, 1, 0, 1, 0, 1};
  logic [31:0] d34 [9]  = '{0, 0, 32'hA5000000, 0, 32'hA5010000, 0, 32'hA5020000, 0, 32'hA5000001};
  logic [2:0]  g35 [11] = '{0, 1, 1, 1, 1, 0, 4, 4, 4, 4, 0};
  logic        v35 [11] = '{0, 0, 1, 1, 1, 1, 0, 1, 1, 1, 1};
  logic [31:0] d35 [11] = '{0, 0, 32'hA0000000, 32'hA0000001, 32'hA0000002, 32'hA0000003, 0,
                            32'hA2000000, 32'hA2000001, 32'hA2000002, 32'hA2000003};
  logic [2:0]  g36 [9]  = '{0, 2, 2, 2, 2, 2, 2, 0, 1};
  logic        v36 [9]  = '{0, 0, 1, 1, 0, 0, 1, 1, 0};
  logic [31:0] d36 [9]  = '{0, 0, 32'hA1000000, 32'hA1000001, 0, 0, 32'hA1000002, 32'hA1000003, 0};
  logic [2:0]  r37 [10] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 0};
  logic        v37 [10] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 0};
  logic [31:0] d37 [10] = '{0, 0, 32'hA5000001, 32'hA5000001, 32'hA5000001, 32'hA5000001,
                            32'hA5000001, 32'hA5000001, 32'hA5000002, 0};

  function automatic logic [31:0] fa(int k, int s);
    return {8'hA5, 8'(k), 16'(s)};
  endfunction

  function automatic logic [31:0] fb(int k, int s);
    return {8'(8'hA0 + k), 24'(s)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic drive_data();
    for (int k = 0; k < 3; k++) begin
      ifa.i_req_data[k*32 +: 32] = fa(k, seqa[k]);
      ifb.i_req_data[k*32 +: 32] = fb(k, seqb[k]);
    end
  endtask

  // Sample point: scoreboard the output, then book every transfer about to happen.
  task automatic smp();
    logic [31:0] e;
    @(negedge clk);
    if (sb_on && ifb.o_data_valid && ifb.i_data_ready) begin
      if (sbq.size() > 0) e = sbq.pop_front();
      else e = 'x;
      chk("sb_data", ifb.o_data, e);
    end
    for (int k = 0; k < 3; k++) begin
      if (ifa.i_req_valid[k] && ifa.o_req_ready[k]) seqa[k]++;
      if (ifb.i_req_valid[k] && ifb.o_req_ready[k]) begin
        if (sb_on) begin
          sbq.push_back(fb(k, seqb[k]));
          if (beat_cnt == 0) owner = k;
          else chk("interleave", 32'(k), 32'(owner));
          beat_cnt++;
          if (beat_cnt == 4) begin
            beat_cnt = 0;
            for (int j = 0; j < 3; j++)
              if (j != owner && want[j]) skip[j]++;
            chk("starve_bound", (skip[owner] > 2) ? 32'd1 : 32'd0, 32'd0);
            skip[owner] = 0;
            want[owner] = 1'b0;
          end
        end
        seqb[k]++;
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    drive_data();
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      seqa[k] = 0; seqb[k] = 0; skip[k] = 0; want[k] = 1'b0;
    end
    ifa.i_req_valid = '0; ifa.i_data_ready = 1'b1;
    ifb.i_req_valid = '0; ifb.i_data_ready = 1'b1;
    drive_data();
    beat_cnt = 0; owner = 0;
    #1 rst_n = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    smp();
    chk("rst_grant_a", 32'(ifa.o_grant), 32'd0);
    chk("rst_ready_a", 32'(ifa.o_req_ready), 32'd0);
    chk("rst_valid_a", 32'(ifa.o_data_valid), 32'd0);
    chk("rst_data_a", ifa.o_data, 32'd0);
    chk("rst_busy_a", 32'(ifa.o_busy), 32'd0);
    chk("rst_grant_b", 32'(ifb.o_grant), 32'd0);
    chk("rst_ready_b", 32'(ifb.o_req_ready), 32'd0);
    chk("rst_valid_b", 32'(ifb.o_data_valid), 32'd0);
    chk("rst_data_b", ifb.o_data, 32'd0);
    chk("rst_busy_b", 32'(ifb.o_busy), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // all three requesters, single-flit packets: 0,1,2,0 with one idle cycle between
    for (int c = 0; c < 9; c++) begin
      ifa.i_req_valid = (c < 8) ? 3'b111 : 3'b000;
      smp();
      chk("rr1_grant", 32'(ifa.o_grant), 32'(g34[c]));
      chk("rr1_busy", 32'(ifa.o_busy), (g34[c] != 0) ? 32'd1 : 32'd0);
      chk("rr1_ready", 32'(ifa.o_req_ready), 32'(g34[c]));
      chk("rr1_valid", 32'(ifa.o_data_valid), 32'(v34[c]));
      if (v34[c]) chk("rr1_data", ifa.o_data, d34[c]);
      adv();
    end

    // 4-flit packets from requesters 0 and 2 never interleave
    for (int c = 0; c < 11; c++) begin
      ifb.i_req_valid = (c < 10) ? 3'b101 : 3'b000;
      smp();
      chk("pkt4_grant", 32'(ifb.o_grant), 32'(g35[c]));
      chk("pkt4_valid", 32'(ifb.o_data_valid), 32'(v35[c]));
      if (v35[c]) chk("pkt4_data", ifb.o_data, d35[c]);
      adv();
    end

    // owner 1 drops valid after two beats; requester 0 must wait for the packet end
    for (int c = 0; c < 13; c++) begin
      ifb.i_req_valid[1] = (c <= 2 || c == 5 || c == 6);
      ifb.i_req_valid[0] = (c >= 1 && c <= 11);
      ifb.i_req_valid[2] = 1'b0;
      smp();
      if (c < 9) begin
        chk("hold_grant", 32'(ifb.o_grant), 32'(g36[c]));
        chk("hold_ready", 32'(ifb.o_req_ready), 32'(g36[c]));
        chk("hold_valid", 32'(ifb.o_data_valid), 32'(v36[c]));
        if (v36[c]) chk("hold_data", ifb.o_data, d36[c]);
      end
      adv();
    end

    // downstream stall of 5 cycles after the first flit
    seqa[0] = 1;
    drive_data();
    for (int c = 0; c < 10; c++) begin
      ifa.i_req_valid  = (c < 8) ? 3'b001 : 3'b000;
      ifa.i_data_ready = !(c >= 2 && c <= 6);
      smp();
      chk("stall_ready", 32'(ifa.o_req_ready), 32'(r37[c]));
      chk("stall_valid", 32'(ifa.o_data_valid), 32'(v37[c]));
      if (v37[c]) chk("stall_data", ifa.o_data, d37[c]);
      adv();
    end
    ifa.i_data_ready = 1'b1;

    // asynchronous reset mid-packet, then requester 0 wins first
    for (int c = 0; c < 3; c++) begin
      ifb.i_req_valid = 3'b100;
      smp();
      chk("prerst_grant", 32'(ifb.o_grant), (c == 0) ? 32'd0 : 32'd4);
      adv();
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_grant", 32'(ifb.o_grant), 32'd0);
    chk("arst_ready", 32'(ifb.o_req_ready), 32'd0);
    chk("arst_valid", 32'(ifb.o_data_valid), 32'd0);
    chk("arst_data", ifb.o_data, 32'd0);
    chk("arst_busy", 32'(ifb.o_busy), 32'd0);
    adv();
    rst_n = 1'b1;
    ifb.i_req_valid = 3'b101;
    smp();
    chk("postrst_idle", 32'(ifb.o_grant), 32'd0);
    adv();
    smp();
    chk("postrst_first", 32'(ifb.o_grant), 32'd1);
    adv();
    ifb.i_req_valid = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // random traffic with scoreboard, interleave and starvation checks
    sbq.delete();
    beat_cnt = 0;
    sb_on = 1'b1;
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int k = 0; k < 3; k++) begin
        if (!want[k] && $urandom_range(0, 3) == 0) want[k] = 1'b1;
        ifb.i_req_valid[k] = want[k] && (!ifb.o_grant[k] || $urandom_range(0, 3) != 0);
      end
      ifb.i_data_ready = ($urandom_range(0, 9) < 7);
      smp();
      adv();
    end
    drained = 1'b0;
    for (int cyc = 0; cyc < 300 && !drained; cyc++) begin
      for (int k = 0; k < 3; k++) ifb.i_req_valid[k] = want[k];
      ifb.i_data_ready = 1'b1;
      smp();
      adv();
      drained = !want[0] && !want[1] && !want[2] && sbq.size() == 0 && !ifb.o_data_valid;
    end
    chk("drain_done", 32'(drained), 32'd1);
    chk("sb_left", 32'(sbq.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
